arm_multicycle_decoder: RTL and testbench

- Main-controller FSM plus instruction decoder for the multi-cycle ARM datapath.
- Takes Op/Funct/Rd from the instruction register and sequences fetch/decode/execute/writeback.
- Produces the unconditioned PCS, RegW, MemW, NoWrite and FlagW consumed by the conditional logic, plus all datapath mux and enable selects.
- Covers ADD, SUB, AND, ORR, CMP (register or immediate), LDR, STR and B.

---
 rtl/arm_multicycle_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_arm_multicycle_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_decoder.sv
// Main-controller FSM and instruction decoder for the multi-cycle ARM datapath.
// Sequences fetch/decode/execute/writeback for ADD, SUB, AND, ORR, CMP, LDR, STR and B.
// It drives the unconditioned PCS/RegW/MemW/NoWrite/FlagW and every datapath select.
// Optional build macro ILLEGAL_OP_TRAP_EN: when defined, this adds an Illegal output and a
// TRAP state. Op=11 and undefined data-processing commands enter TRAP, which the FSM
// leaves only on Reset.

module arm_multicycle_decoder (
    input  logic       clk,
    input  logic       Reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic [1:0] FlagW,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       Illegal
`endif
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  w_cmd;
    logic [1:0]  w_alu_dec;
    logic        w_flag_arith;
    logic        w_is_cmp;
    logic        w_regw;
    logic        w_branch;

    assign w_cmd        = Funct[4:1];
    assign w_is_cmp     = (Op == 2'b00) && (w_cmd == 4'b1010);
    assign w_flag_arith = (w_cmd == 4'b0100) || (w_cmd == 4'b0010) || (w_cmd == 4'b1010);

`ifdef ILLEGAL_OP_TRAP_EN
    logic w_cmd_defined;
    assign w_cmd_defined = (w_cmd == 4'b0100) || (w_cmd == 4'b0010) || (w_cmd == 4'b0000) ||
                           (w_cmd == 4'b1100) || (w_cmd == 4'b1010);
`endif

    // Data-processing command to ALU operation; unknown commands fall back to ADD
    always_comb begin
        w_alu_dec = 2'b00;
        case (w_cmd)
            4'b0100: w_alu_dec = 2'b00;
            4'b0010: w_alu_dec = 2'b01;
            4'b0000: w_alu_dec = 2'b10;
            4'b1100: w_alu_dec = 2'b11;
            4'b1010: w_alu_dec = 2'b01;
            default: w_alu_dec = 2'b00;
        endcase
    end

    // State register; synchronous reset returns to FETCH
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing from the held instruction fields
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   w_next_state = S_MEMADR;
                    2'b00:   w_next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   w_next_state = S_BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
                    default: w_next_state = S_TRAP;
`else
                    default: w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            S_EXECUTER,
            S_EXECUTEI: w_next_state = w_cmd_defined ? S_ALUWB : S_TRAP;
            S_TRAP:     w_next_state = S_TRAP;
`else
            S_EXECUTER,
            S_EXECUTEI: w_next_state = S_ALUWB;
`endif
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Moore outputs per state, all forced low while Reset is high
    always_comb begin
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        w_regw     = 1'b0;
        MemW       = 1'b0;
        w_branch   = 1'b0;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
        Illegal    = 1'b0;
`endif
        if (!Reset) begin
            ImmSrc = Op;
            RegSrc = {Op == 2'b01, Op == 2'b10};
            case (r_state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    NoWrite   = w_is_cmp;
                end
                S_MEMADR: begin
                    ALUSrcB   = 2'b01;
                end
                S_MEMREAD: begin
                    AdrSrc    = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    w_regw    = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc    = 1'b1;
                    MemW      = 1'b1;
                end
                S_EXECUTER, S_EXECUTEI: begin
                    ALUSrcB    = (r_state == S_EXECUTEI) ? 2'b01 : 2'b00;
                    ALUControl = w_alu_dec;
                    FlagW      = {Funct[0], Funct[0] & w_flag_arith};
                    NoWrite    = w_is_cmp;
                end
                S_ALUWB: begin
                    w_regw    = 1'b1;
                    NoWrite   = w_is_cmp;
                end
                S_BRANCH: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    w_branch  = 1'b1;
                end
`ifdef ILLEGAL_OP_TRAP_EN
                S_TRAP: begin
                    Illegal   = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign RegW = w_regw;
    assign PCS  = (w_regw && (Rd == 4'hF)) || w_branch;

endmodule

// File: tb/tb_arm_multicycle_decoder.sv
// Randomised scoreboard bench for arm_multicycle_decoder.
// Each instruction expands into its per-cycle expected output vectors; a monitor checks one per cycle.

module tb_arm_multicycle_decoder;

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowrite;
        logic [1:0] flagw;
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluctl;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic       illegal;
    } outv_t;

    typedef struct {
        outv_t v;
        int    instr;
        int    cyc;
    } exp_t;

    localparam int ST_F    = 0;
    localparam int ST_D    = 1;
    localparam int ST_MA   = 2;
    localparam int ST_MR   = 3;
    localparam int ST_MWB  = 4;
    localparam int ST_MW   = 5;
    localparam int ST_ER   = 6;
    localparam int ST_EI   = 7;
    localparam int ST_AWB  = 8;
    localparam int ST_BR   = 9;
    localparam int ST_TRAP = 10;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif

    logic       clk;
    logic       Reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc;
    logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic       ill;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   instr_no = 0;

    arm_multicycle_decoder dut (
        .clk        (clk),
        .Reset      (Reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .FlagW      (FlagW),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .Illegal    (ill)
`endif
    );

`ifndef ILLEGAL_OP_TRAP_EN
    assign ill = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ALU operation for a data-processing command
    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            4'b1010: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit cmd_defined(input logic [3:0] cmd);
        return (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) ||
               (cmd == 4'b1100) || (cmd == 4'b1010);
    endfunction

    // Reference: expected outputs for one step of an instruction
    function automatic outv_t stage_vec(input int st, input logic [1:0] op,
                                        input logic [5:0] fn, input logic [3:0] rd);
        outv_t      v;
        logic [3:0] cmd;
        logic       cmp;
        logic       arith;
        v     = '0;
        cmd   = fn[4:1];
        cmp   = (op == 2'b00) && (cmd == 4'b1010);
        arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        v.immsrc = op;
        v.regsrc = {op == 2'b01, op == 2'b10};
        case (st)
            ST_F:   begin v.irwrite = 1'b1; v.nextpc = 1'b1; v.alusrca = 2'b01;
                          v.alusrcb = 2'b10; v.resultsrc = 2'b10; end
            ST_D:   begin v.alusrca = 2'b01; v.alusrcb = 2'b10; v.resultsrc = 2'b10;
                          v.nowrite = cmp; end
            ST_MA:  begin v.alusrcb = 2'b01; end
            ST_MR:  begin v.adrsrc = 1'b1; end
            ST_MWB: begin v.resultsrc = 2'b01; v.regw = 1'b1; v.pcs = (rd == 4'd15); end
            ST_MW:  begin v.adrsrc = 1'b1; v.memw = 1'b1; end
            ST_ER, ST_EI: begin
                v.alusrcb = (st == ST_EI) ? 2'b01 : 2'b00;
                v.aluctl  = alu_of(cmd);
                v.flagw   = {fn[0], fn[0] & arith};
                v.nowrite = cmp;
            end
            ST_AWB: begin v.regw = 1'b1; v.nowrite = cmp; v.pcs = (rd == 4'd15); end
            ST_BR:  begin v.alusrca = 2'b10; v.alusrcb = 2'b01; v.resultsrc = 2'b10;
                          v.pcs = 1'b1; end
            ST_TRAP: begin v.illegal = 1'b1; end
            default: begin end
        endcase
        return v;
    endfunction

    task automatic drive_cycle(input outv_t v, input int cyc);
        exp_t e;
        Reset = 1'b0;
        e.v = v; e.instr = instr_no; e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle(input int cyc);
        exp_t e;
        Reset = 1'b1;
        e.v = '0; e.instr = instr_no; e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        Reset = 1'b0;
    endtask

    // Issue one instruction; abort_at >= 0 asserts Reset in that cycle instead
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input int abort_at);
        int st[$];
        bit trapped;
        trapped = 1'b0;
        st.push_back(ST_F);
        st.push_back(ST_D);
        case (op)
            2'b01: begin
                st.push_back(ST_MA);
                if (fn[0]) begin st.push_back(ST_MR); st.push_back(ST_MWB); end
                else       st.push_back(ST_MW);
            end
            2'b00: begin
                st.push_back(fn[5] ? ST_EI : ST_ER);
                if (TRAP_BUILD && !cmd_defined(fn[4:1])) trapped = 1'b1;
                else st.push_back(ST_AWB);
            end
            2'b10: st.push_back(ST_BR);
            default: if (TRAP_BUILD) trapped = 1'b1;
        endcase
        if (trapped) repeat (3) st.push_back(ST_TRAP);
        Op = op; Funct = fn; Rd = rd;
        for (int c = 0; c < st.size(); c++) begin
            if (c == abort_at) begin
                reset_cycle(c);
                instr_no++;
                return;
            end
            drive_cycle(stage_vec(st[c], op, fn, rd), c);
        end
        if (trapped) reset_cycle(st.size());
        instr_no++;
    endtask

    // Monitor: one expected vector per cycle, compared mid-cycle
    initial begin
        exp_t  e;
        outv_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {PCS, RegW, MemW, NoWrite, FlagW, IRWrite, NextPC, AdrSrc,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, ill};
                n_checks++;
                if (act === e.v) n_pass++;
                else $display("FAIL outputs instr=%0d cyc=%0d op=%b funct=%b rd=%0d got=%h want=%h",
                              e.instr, e.cyc, Op, Funct, Rd, act, e.v);
            end
        end
    end

    // Stimulus: directed test-plan cases, then randomised instructions
    initial begin
        logic [3:0] cmds [5];
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] rd;
        logic [3:0] cmd;
        int         abort;
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010;
        Reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        @(posedge clk);
        #1;
        reset_cycle(0);
        reset_cycle(0);

        run_instr(2'b00, 6'b001001, 4'd1,  -1);  // ADDS R1,R2,R3
        run_instr(2'b00, 6'b110101, 4'd0,  -1);  // CMP R1,#5
        run_instr(2'b01, 6'b011001, 4'd15, -1);  // LDR R15,[R0]
        run_instr(2'b01, 6'b011000, 4'd2,  -1);  // STR
        run_instr(2'b10, 6'b101000, 4'd0,  -1);  // B
        run_instr(2'b11, 6'b000000, 4'd3,  -1);  // Op=11
        run_instr(2'b00, 6'b011000, 4'd15, -1);  // ORR R15 -> PCS in ALUWB
        run_instr(2'b01, 6'b011000, 4'd4,  3);   // Reset during MEMWRITE
        run_instr(2'b01, 6'b011001, 4'd15, 4);   // Reset during MEMWB
        run_instr(2'b00, 6'b000101, 4'd5,  -1);  // SUBS after aborted ops

        for (int i = 0; i < 120; i++) begin
            op  = 2'($urandom_range(0, 3));
            rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            cmd = ($urandom_range(0, 4) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 4)];
            fn  = {1'($urandom), cmd, 1'($urandom)};
            abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, fn, rd, abort);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
